// File: rtl/tile_map_controller.sv
// tile_map_controller: per-tile type map for the playfield. Registered pixel-to-tile
// lookup for the renderer, vblank-gated game-logic writes, and an init sweep that
// restores the default map while tracking how many GIFT cells are present.
module tile_map_controller #(
    parameter int unsigned TILE_X_BITS = 6,
    parameter int unsigned TILE_Y_BITS = 5,
    parameter int unsigned NUM_COLS    = 10,
    parameter int unsigned NUM_ROWS    = 15,
    parameter int unsigned FLOOR_ROW   = 14
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        vblank,
    input  logic        wr_req,
    input  logic [3:0]  wr_col,
    input  logic [3:0]  wr_row,
    input  logic [1:0]  wr_type,
    input  logic        init_req,
    output logic [1:0]  Tile_type,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        wr_ack,
    output logic        busy,
    output logic [7:0]  gift_count
);

    localparam int unsigned PIX_W  = 11;
    localparam int unsigned CIDX_W = $clog2(NUM_COLS);
    localparam int unsigned RIDX_W = $clog2(NUM_ROWS);
    localparam int unsigned GIFT_W = 8;

    localparam logic [PIX_W-1:0]  COLS_PIX  = PIX_W'(NUM_COLS);
    localparam logic [PIX_W-1:0]  ROWS_PIX  = PIX_W'(NUM_ROWS);
    localparam logic [3:0]        COLS_WR   = 4'(NUM_COLS);
    localparam logic [3:0]        ROWS_WR   = 4'(NUM_ROWS);
    localparam logic [CIDX_W-1:0] LAST_COL  = CIDX_W'(NUM_COLS - 1);
    localparam logic [RIDX_W-1:0] LAST_ROW  = RIDX_W'(NUM_ROWS - 1);
    localparam logic [RIDX_W-1:0] FLOOR_IDX = RIDX_W'(FLOOR_ROW);
    localparam logic [GIFT_W-1:0] GIFT_MAX  = '1;

    localparam logic [1:0] T_BG    = 2'b00;
    localparam logic [1:0] T_FLOOR = 2'b01;
    localparam logic [1:0] T_GIFT  = 2'b10;
    localparam logic [1:0] T_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_INIT  = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        map_q [NUM_ROWS][NUM_COLS];

    logic [CIDX_W-1:0] init_col_q;
    logic [RIDX_W-1:0] init_row_q;
    logic [3:0]        wr_col_q;
    logic [3:0]        wr_row_q;
    logic [1:0]        wr_type_q;

    logic              map_we;
    logic [RIDX_W-1:0] map_row;
    logic [CIDX_W-1:0] map_col;
    logic [1:0]        map_data;
    logic              sweep_last;
    logic              wr_valid;
    logic [1:0]        old_type;
    logic              gift_inc;
    logic              gift_dec;

    logic [PIX_W-1:0]  pix_col;
    logic [PIX_W-1:0]  pix_row;
    logic              pix_in_range;
    logic [1:0]        pix_type;

    // Default map content for a given row: floor row is FLOOR, everything else BACKGROUND
    function automatic logic [1:0] default_type(input logic [RIDX_W-1:0] r);
        return (r == FLOOR_IDX) ? T_FLOOR : T_BG;
    endfunction

    // Latched write is legal only for an on-map cell and a defined type
    assign wr_valid = (wr_col_q < COLS_WR) && (wr_row_q < ROWS_WR) && (wr_type_q != T_RSVD);

    // Next-state, map write port and gift-count deltas
    always_comb begin
        state_d    = state_q;
        map_we     = 1'b0;
        map_row    = '0;
        map_col    = '0;
        map_data   = T_BG;
        sweep_last = 1'b0;
        old_type   = T_BG;
        gift_inc   = 1'b0;
        gift_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                end else if (wr_req && vblank) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (wr_valid) begin
                    map_we   = 1'b1;
                    map_row  = RIDX_W'(wr_row_q);
                    map_col  = CIDX_W'(wr_col_q);
                    map_data = wr_type_q;
                    old_type = map_q[RIDX_W'(wr_row_q)][CIDX_W'(wr_col_q)];
                    gift_inc = (old_type != T_GIFT) && (wr_type_q == T_GIFT);
                    gift_dec = (old_type == T_GIFT) && (wr_type_q != T_GIFT);
                end
            end
            ST_INIT: begin
                map_we   = 1'b1;
                map_row  = init_row_q;
                map_col  = init_col_q;
                map_data = default_type(init_row_q);
                if ((init_col_q == LAST_COL) && (init_row_q == LAST_ROW)) begin
                    sweep_last = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, sweep cursor and captured write request
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            init_col_q <= '0;
            init_row_q <= '0;
            wr_col_q   <= '0;
            wr_row_q   <= '0;
            wr_type_q  <= T_BG;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && (state_d == ST_WRITE)) begin
                wr_col_q  <= wr_col;
                wr_row_q  <= wr_row;
                wr_type_q <= wr_type;
            end
            if (state_q == ST_INIT) begin
                if (init_col_q == LAST_COL) begin
                    init_col_q <= '0;
                    init_row_q <= sweep_last ? '0 : init_row_q + RIDX_W'(1);
                end else begin
                    init_col_q <= init_col_q + CIDX_W'(1);
                end
            end
        end
    end

    // Tile map storage; reset loads the default pattern directly
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    map_q[RIDX_W'(r)][CIDX_W'(c)] <= default_type(RIDX_W'(r));
                end
            end
        end else if (map_we) begin
            map_q[map_row][map_col] <= map_data;
        end
    end

    // Pixel to tile cell decode; reads the pre-commit map contents
    always_comb begin
        pix_col      = pixelX >> TILE_X_BITS;
        pix_row      = pixelY >> TILE_Y_BITS;
        pix_in_range = (pix_col < COLS_PIX) && (pix_row < ROWS_PIX);
        pix_type     = T_BG;
        if (pix_in_range) begin
            pix_type = map_q[RIDX_W'(pix_row)][CIDX_W'(pix_col)];
        end
    end

    // Renderer outputs, registered together; type blanked while the sweep runs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            Tile_type <= T_BG;
            offsetX   <= '0;
            offsetY   <= '0;
        end else begin
            Tile_type <= (state_d == ST_INIT) ? T_BG : pix_type;
            offsetX   <= pix_in_range ? PIX_W'(pixelX[TILE_X_BITS-1:0]) : '0;
            offsetY   <= pix_in_range ? PIX_W'(pixelY[TILE_Y_BITS-1:0]) : '0;
        end
    end

    // Handshake/status outputs and saturating gift counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ack     <= 1'b0;
            busy       <= 1'b0;
            gift_count <= '0;
        end else begin
            wr_ack <= (state_d == ST_WRITE);
            busy   <= (state_d == ST_INIT);
            if (sweep_last) begin
                gift_count <= '0;
            end else if (gift_inc && (gift_count != GIFT_MAX)) begin
                gift_count <= gift_count + GIFT_W'(1);
            end else if (gift_dec && (gift_count != '0)) begin
                gift_count <= gift_count - GIFT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tile_map_controller.sv
// Scoreboard bench for tile_map_controller: stimulus pushes expectations computed
// from a plain array model of the playfield; a monitor pops and compares.
`timescale 1ns/1ps
module tb_tile_map_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        vblank, wr_req, init_req;
    logic [3:0]  wr_col, wr_row;
    logic [1:0]  wr_type;
    logic [1:0]  Tile_type;
    logic [10:0] offsetX, offsetY;
    logic        wr_ack, busy;
    logic [7:0]  gift_count;

    tile_map_controller dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .vblank(vblank), .wr_req(wr_req), .wr_col(wr_col), .wr_row(wr_row),
        .wr_type(wr_type), .init_req(init_req), .Tile_type(Tile_type),
        .offsetX(offsetX), .offsetY(offsetY), .wr_ack(wr_ack), .busy(busy),
        .gift_count(gift_count)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int ox; int oy; } look_t;

    int    checks = 0;
    int    errors = 0;
    int    model_map [15][10];
    look_t look_q [$];
    int    gift_q [$];
    int    cyc = 0;
    int    busy_fall_cyc = -100;
    int    ack_cyc = -1;
    int    busy_run = 0;
    bit    busy_prev = 0;
    bit    ack_prev = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Playfield model: 64x32 tiles, 10x15 grid, floor on row 14
    function automatic void model_default();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 10; c++)
                model_map[r][c] = (r == 14) ? 1 : 0;
    endfunction

    function automatic void model_write(input int c, input int r, input int t);
        if (c < 10 && r < 15 && t != 3) model_map[r][c] = t;
    endfunction

    function automatic int model_gifts();
        int n = 0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 10; c++)
                if (model_map[r][c] == 2) n++;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic look_t model_look(input int px, input int py);
        look_t e;
        int c = px / 64;
        int r = py / 32;
        if (c < 10 && r < 15) begin
            e.t = model_map[r][c]; e.ox = px % 64; e.oy = py % 32;
        end else begin
            e.t = 0; e.ox = 0; e.oy = 0;
        end
        return e;
    endfunction

    // Monitor: pops expectations as the DUT presents results
    initial begin
        look_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!resetN) begin
                busy_run = 0; busy_prev = 0; ack_prev = 0;
                continue;
            end
            if (look_q.size() > 0) begin
                e = look_q.pop_front();
                chk("tile_type", int'(Tile_type), e.t);
                chk("offsetX", int'(offsetX), e.ox);
                chk("offsetY", int'(offsetY), e.oy);
            end
            if (ack_prev) begin
                if (gift_q.size() > 0) chk("gift_count", int'(gift_count), gift_q.pop_front());
                else begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got wr_ack with no request outstanding");
                end
            end
            if (busy) begin
                busy_run++;
                chk("tile_type_during_init", int'(Tile_type), 0);
                chk("ack_during_init", int'(wr_ack), 0);
            end else if (busy_prev) begin
                chk("busy_length", busy_run, 150);
                chk("gift_after_init", int'(gift_count), 0);
                busy_fall_cyc = cyc;
                busy_run = 0;
            end
            if (wr_ack) ack_cyc = cyc;
            ack_prev  = wr_ack;
            busy_prev = busy;
        end
    end

    task automatic lookup_one(input int px, input int py);
        @(negedge clk);
        pixelX = 11'(px); pixelY = 11'(py);
        look_q.push_back(model_look(px, py));
    endtask

    task automatic run_lookups(input int n);
        int px, py;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                px = $urandom_range(0, 799); py = $urandom_range(0, 524);
            end else begin
                px = $urandom_range(0, 2047); py = $urandom_range(0, 2047);
            end
            lookup_one(px, py);
        end
    endtask

    task automatic do_write(input int c, input int r, input int t, input int hold_off);
        bit got = 0;
        @(negedge clk);
        wr_req = 1'b1; wr_col = 4'(c); wr_row = 4'(r); wr_type = 2'(t); vblank = 1'b0;
        for (int i = 0; i < hold_off; i++) begin
            @(negedge clk);
            chk("no_ack_without_vblank", int'(wr_ack), 0);
        end
        vblank = 1'b1;
        model_write(c, r, t);
        gift_q.push_back(model_gifts());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_ack) begin got = 1; break; end
        end
        chk("write_acked", int'(got), 1);
        wr_req = 1'b0; vblank = 1'b0;
        @(negedge clk);
        chk("ack_single_pulse", int'(wr_ack), 0);
    endtask

    task automatic do_init(input bit poke_again);
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
        model_default();
        chk("busy_rise", int'(busy), 1);
        if (poke_again) begin
            repeat (20) @(negedge clk);
            init_req = 1'b1;
            @(negedge clk); init_req = 1'b0;
        end
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk("busy_fall", int'(busy), 0);
    endtask

    initial begin
        bit got;
        resetN = 1'b0; pixelX = '0; pixelY = '0; vblank = 1'b0; wr_req = 1'b0;
        wr_col = '0; wr_row = '0; wr_type = '0; init_req = 1'b0;
        model_default();
        repeat (3) @(negedge clk);
        chk("reset_tile_type", int'(Tile_type), 0);
        chk("reset_offsetX", int'(offsetX), 0);
        chk("reset_offsetY", int'(offsetY), 0);
        chk("reset_wr_ack", int'(wr_ack), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_gift", int'(gift_count), 0);
        resetN = 1'b1;

        // Default map and out-of-range pixels
        lookup_one(0, 0);
        lookup_one(130, 455);
        lookup_one(700, 100);
        lookup_one(10, 500);
        lookup_one(639, 479);
        lookup_one(640, 479);
        run_lookups(60);

        // Gift write held off by vblank, then clear and re-clear
        do_write(3, 5, 2, 20);
        lookup_one(200, 170);
        do_write(3, 5, 0, 0);
        do_write(3, 5, 0, 1);
        lookup_one(200, 170);

        // Illegal writes are acked but leave the map alone
        do_write(12, 3, 2, 0);
        do_write(2, 15, 2, 0);
        do_write(1, 1, 3, 0);
        lookup_one(64, 32);

        // Randomised writes then random reads against the model
        for (int i = 0; i < 30; i++)
            do_write($urandom_range(0, 11), $urandom_range(0, 15),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 2,
                     $urandom_range(0, 2));
        run_lookups(150);

        // Three gifts, init sweep with a second init_req ignored
        do_write(3, 5, 2, 0);
        do_write(7, 5, 2, 0);
        do_write(9, 14, 2, 0);
        do_init(1'b1);
        lookup_one(200, 170);
        lookup_one(600, 460);
        lookup_one(130, 455);
        run_lookups(40);

        // Async reset in the middle of an init sweep
        do_write(4, 6, 2, 0);
        do_write(8, 13, 2, 0);
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        model_default();
        @(negedge clk);
        chk("midinit_reset_busy", int'(busy), 0);
        chk("midinit_reset_gift", int'(gift_count), 0);
        chk("midinit_reset_type", int'(Tile_type), 0);
        @(negedge clk); resetN = 1'b1;
        lookup_one(4 * 64 + 5, 6 * 32 + 3);
        lookup_one(8 * 64 + 1, 13 * 32 + 31);
        run_lookups(30);

        // Simultaneous init_req and write: init wins, write follows
        do_write(5, 2, 2, 0);
        @(negedge clk);
        init_req = 1'b1; wr_req = 1'b1; wr_col = 4'd0; wr_row = 4'd0; wr_type = 2'd2; vblank = 1'b1;
        model_default();
        model_write(0, 0, 2);
        gift_q.push_back(model_gifts());
        @(negedge clk); init_req = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ack) begin got = 1; break; end
        end
        chk("pending_write_acked", int'(got), 1);
        chk("ack_after_init_end", ack_cyc - busy_fall_cyc, 1);
        wr_req = 1'b0; vblank = 1'b0;
        @(negedge clk);
        lookup_one(0, 0);
        lookup_one(5 * 64, 2 * 32);
        lookup_one(130, 455);

        repeat (4) @(negedge clk);
        chk("lookup_queue_drained", look_q.size(), 0);
        chk("gift_queue_drained", gift_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
